// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART receiver.
package uart_host_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;

  typedef struct packed {
    logic parity;
    logic frame;
  } rx_err_t;
endpackage

// File: rtl/uart_host_baud_gen.sv
// 16x oversample tick generator: one tick every div_i clocks (0 treated as 1).
module uart_host_baud_gen (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] div_i,
  output logic        tick_o
);
  logic [15:0] cnt;

  // Reload at 1 so a period is exactly div_i clocks; div_i of 0 or 1 ticks every clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (cnt <= 16'd1) begin
      cnt    <= div_i;
      tick_o <= 1'b1;
    end else begin
      cnt    <= cnt - 16'd1;
      tick_o <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_host_rx.sv
// Host-side UART receiver: oversampled mid-bit sampling, valid/ready output with overrun drop.
module uart_host_rx
  import uart_host_pkg::*;
#(
  parameter int N_DATA_BITS     = 8,
  parameter int PARITY_EN       = 0,
  parameter int SINGLE_STOP_BIT = 1,
  parameter int LSB_FIRST       = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] div_i,
  input  logic        srx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);
  localparam int NB = N_DATA_BITS;

  logic            s1, s2, s_prev;
  logic [1:0]      settle;
  logic            tick, fall, sample, done;
  rx_state_e       state, state_nx;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [NB-1:0]   sr;
  rx_err_t         err;

  uart_host_baud_gen u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // Edges are only trusted once the reset-preset flops have flushed, so a line
  // held low across reset release cannot masquerade as a start edge.
  assign fall   = (settle == 2'd3) && s_prev && !s2;
  assign busy_o = (state != IDLE);

  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    done     = 1'b0;
    if (tick)
      sample = (state == START) ? (tick_cnt == 4'(MID_SAMPLE - 1))
                                : (tick_cnt == 4'(OVERSAMPLE - 1));
    case (state)
      IDLE:      if (fall) state_nx = START;
      START:     if (sample) state_nx = s2 ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == 3'(NB - 1))
                   state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (sample) state_nx = STOP;
      STOP:      if (sample && (SINGLE_STOP_BIT != 0 || bit_cnt == 3'd1)) begin
                   done     = 1'b1;
                   state_nx = s2 ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (s2) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      s1           <= 1'b1;
      s2           <= 1'b1;
      s_prev       <= 1'b1;
      settle       <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      err          <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      s1        <= srx_i;
      s2        <= s1;
      s_prev    <= s2;
      if (settle != 2'd3) settle <= settle + 2'd1;
      state     <= state_nx;
      overrun_o <= 1'b0;

      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        err      <= '0;
      end else if (tick) begin
        tick_cnt <= sample ? 4'd0 : tick_cnt + 4'd1;
      end

      if (sample) begin
        case (state)
          DATA: begin
            sr      <= (LSB_FIRST != 0) ? {s2, sr[NB-1:1]} : {sr[NB-2:0], s2};
            bit_cnt <= (bit_cnt == 3'(NB - 1)) ? 3'd0 : bit_cnt + 3'd1;
          end
          PARITY:  err.parity <= (s2 != ^sr);
          STOP: begin
            err.frame <= err.frame | ~s2;
            bit_cnt   <= bit_cnt + 3'd1;
          end
          default: ;
        endcase
      end

      // A completing frame wins over a plain acceptance; it is dropped only if the held byte stays.
      if (done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= 8'(sr);
          rx_valid_o   <= 1'b1;
          parity_err_o <= err.parity;
          frame_err_o  <= err.frame | ~s2;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_host_rx.sv
// Scoreboard bench for uart_host_rx: directed frames, monitor checks every accepted byte.
module tb_uart_host_rx;
  import uart_host_pkg::*;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] div = 16'(DIV);
  logic        srx = 1'b1, srx_p = 1'b1, ready = 1'b1;
  logic [7:0]  data, data_p;
  logic        valid, valid_p, perr, perr_p, ferr, ferr_p, ovr, ovr_p, busy, busy_p;

  int   checks = 0, passed = 0, ovr_cnt = 0;
  exp_t q[$], qp[$];
  exp_t e_m, e_p;

  always #5 clk = ~clk;

  uart_host_rx u_dut (
    .clk(clk), .rstn(rstn), .div_i(div), .srx_i(srx),
    .rx_data_o(data), .rx_valid_o(valid), .rx_ready_i(ready),
    .parity_err_o(perr), .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy)
  );

  uart_host_rx #(.PARITY_EN(1)) u_par (
    .clk(clk), .rstn(rstn), .div_i(div), .srx_i(srx_p),
    .rx_data_o(data_p), .rx_valid_o(valid_p), .rx_ready_i(1'b1),
    .parity_err_o(perr_p), .frame_err_o(ferr_p), .overrun_o(ovr_p), .busy_o(busy_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) if (rstn) begin
    if (ovr) ovr_cnt++;
    if (valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        e_m = q.pop_front();
        check("rx_byte", {perr, ferr, data}, {e_m.pe, e_m.fe, e_m.d});
      end
    end
    if (valid_p) begin
      if (qp.size() == 0) begin
        checks++;
        $display("FAIL unexpected_par_byte: got %0h expected none", data_p);
      end else begin
        e_p = qp.pop_front();
        check("par_byte", {perr_p, ferr_p, data_p}, {e_p.pe, e_p.fe, e_p.d});
      end
    end
  end

  task automatic drive(input bit p, input logic v, input int n);
    if (p) srx_p = v; else srx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit p, input logic [7:0] d, input bit par_en,
                      input logic par_bit, input logic stop);
    drive(p, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(p, d[i], BIT);
    if (par_en) drive(p, par_bit, BIT);
    drive(p, stop, BIT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit seen;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_flags", {valid, perr, ferr, ovr, busy}, 5'b0);
    rstn = 1'b1;
    drive(0, 1'b1, 2 * BIT);

    // 8N1 0xA5 with latency measured from the start edge
    q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    lat = 0;
    seen = 0;
    fork
      send(0, 8'hA5, 0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 1000 && !seen; i++) begin
          @(posedge clk); #1;
          lat++;
          if (valid) seen = 1;
        end
      end
    join
    check("a5_latency_in_600_660", (seen && lat >= 600 && lat <= 660), 1);

    // start-bit glitch
    drive(0, 1'b0, 20);
    check("glitch_busy", busy, 1'b1);
    drive(0, 1'b1, BIT);
    check("glitch_idle", busy, 1'b0);

    // even parity
    qp.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0});
    send(1, 8'h03, 1, 1'b1, 1'b1);
    qp.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
    send(1, 8'h07, 1, 1'b1, 1'b1);

    // framing error followed by break, then a clean frame
    q.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b1});
    send(0, 8'hC3, 0, 1'b0, 1'b0);
    check("break_wait_idle", u_dut.state, WAIT_IDLE);
    drive(0, 1'b0, 3 * BIT);
    check("break_still_busy", busy, 1'b1);
    drive(0, 1'b1, BIT);
    check("break_released", busy, 1'b0);
    q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);

    // overrun, then acceptance coinciding with completion
    ready = 1'b0;
    q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(0, 8'h11, 0, 1'b0, 1'b1);
    check("hold_11", {valid, data}, {1'b1, 8'h11});
    send(0, 8'h22, 0, 1'b0, 1'b1);
    check("overrun_once", ovr_cnt, 1);
    check("kept_11", {valid, data}, {1'b1, 8'h11});
    q.push_back('{d: 8'h33, pe: 1'b0, fe: 1'b0});
    seen = 0;
    fork
      send(0, 8'h33, 0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 1000 && !seen; i++) begin
          @(posedge clk); #1;
          if (u_dut.done) begin
            seen = 1;
            ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
          end
        end
      end
    join
    check("done_seen", seen, 1'b1);
    check("present_33", {valid, data}, {1'b1, 8'h33});
    check("no_new_overrun", ovr_cnt, 1);
    ready = 1'b1;
    drive(0, 1'b1, BIT);

    // reset during data bit 3 with the line low
    drive(0, 1'b0, 4 * BIT + BIT / 2);
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_flags", {valid, perr, ferr, ovr, busy}, 5'b0);
    rstn = 1'b1;
    drive(0, 1'b0, 2 * BIT);
    check("no_false_start", busy, 1'b0);
    drive(0, 1'b1, BIT);
    q.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b0});
    send(0, 8'h7E, 0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);

    check("queues_drained", q.size() + qp.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_host_rx.md
UART_HOST_RX -- requirements
Module: uart_host_rx

Interface
REQ-001 SHALL have parameter N_DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0; when set, one even-parity bit follows the data bits.
REQ-003 SHALL have parameter SINGLE_STOP_BIT, default 1; 1 means one stop bit, 0 means two stop bits.
REQ-004 SHALL have parameter LSB_FIRST, default 1; 1 means data bit 0 arrives first, 0 means MSB first.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port div_i, input, 16, baud divisor: one 16x-oversample tick every div_i clocks.
REQ-008 SHALL have port srx_i, input, 1, serial line from the device (the device's stx_pad_o); idles high.
REQ-009 SHALL have port rx_data_o, output, 8, received byte, right-aligned; unused upper bits are 0.
REQ-010 SHALL have port rx_valid_o, output, 1, held byte available.
REQ-011 SHALL have port rx_ready_i, input, 1, consumer accepts the held byte.
REQ-012 SHALL have port parity_err_o, output, 1, parity error flag qualified by rx_valid_o.
REQ-013 SHALL have port frame_err_o, output, 1, stop-bit error flag qualified by rx_valid_o.
REQ-014 SHALL have port overrun_o, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass srx_i through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-017 SHALL generate the oversample tick from a 16-bit down-counter reloaded with div_i; div_i=0 SHALL behave as 1; a div_i change SHALL take effect at the next reload.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 IDLE->START SHALL occur on a synchronized high-to-low edge, with the tick phase counter cleared.
REQ-020 In START the FSM SHALL sample at tick 8; if the line is high (glitch), SHALL return to IDLE with no output.
REQ-021 Each subsequent bit SHALL be sampled once, 16 ticks after the previous sample (mid-bit).
REQ-022 DATA SHALL collect N_DATA_BITS samples, placed according to LSB_FIRST, then go to PARITY if PARITY_EN, else to STOP.
REQ-023 PARITY SHALL flag an error when the sampled bit differs from the XOR of the data bits.
REQ-024 STOP SHALL sample 1 or 2 stop bits; any low stop sample SHALL set the frame error.
REQ-025 On the last stop sample, the frame SHALL complete: go to IDLE if the line is high, otherwise to WAIT_IDLE, which exits to IDLE when the line returns high (break).
REQ-026 On completion, rx_valid_o SHALL assert on the next clock, with data and flags registered; a byte with frame_err is still delivered.
REQ-027 Handshake: the byte SHALL be transferred when rx_valid_o && rx_ready_i; rx_valid_o and data SHALL stay stable until then.
REQ-028 Completion while the held byte is not accepted: the new frame SHALL be discarded, overrun_o SHALL pulse, and the held byte SHALL be kept.
REQ-029 Completion in the same cycle as acceptance: the new byte SHALL load, rx_valid_o SHALL stay high, and there is no overrun.

Reset
REQ-030 While rstn=0 at a clk edge: FSM=IDLE, counters=0, synchronizer flops=1, rx_data_o=0, and all flag/valid/busy outputs=0.
REQ-031 Reset mid-frame SHALL abort the frame with no output; reception SHALL restart only on a new falling edge after reset release.

Structure
REQ-032 Package uart_host_pkg SHALL hold the FSM state enum, the OVERSAMPLE=16 and MID_SAMPLE=8 constants, and the frame-error type.
REQ-033 The tick generator SHALL be sub-module uart_host_baud_gen (clk, rstn, div_i, tick_o).

Verification
REQ-034 div_i=4, frame 0xA5 (8N1, LSB first) -> rx_data_o=0xA5, rx_valid_o high, both error flags 0, valid about 640 clocks after the start edge.
REQ-035 Low pulse of 20 clocks on an idle line with div_i=4 -> no rx_valid_o, busy_o returns to 0.
REQ-036 PARITY_EN=1, 0x03 sent with parity bit 1 -> rx_data_o=0x03, parity_err_o=1.
REQ-037 Stop bit driven 0 then line held low for 3 bit times -> frame_err_o=1, FSM in WAIT_IDLE, next frame 0x5A received clean after the line goes high.
REQ-038 rx_ready_i=0, frames 0x11 then 0x22 -> overrun_o pulses once, rx_data_o stays 0x11; ready pulsed at 0x33 completion -> 0x11 accepted, then 0x33 presented.
REQ-039 rstn=0 asserted during data bit 3 -> all outputs 0; a subsequent 0x7E frame is received correctly.
